// File: rtl/sa_cache_ctrl.sv
// sa_cache_ctrl: N-way set-associative write-through, no-write-allocate cache with round-robin replacement
module sa_cache_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WAYS   = 2,
  parameter int NUM_SETS   = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush_i,
  input  logic                    req_i,
  output logic                    gnt_o,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic                    rvalid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    mem_req_o,
  input  logic                    mem_gnt_i,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  output logic [31:0]             hit_count_o,
  output logic [31:0]             miss_count_o
);
  localparam int BW  = DATA_WIDTH / 8;
  localparam int OB  = $clog2(BW);
  localparam int WB  = $clog2(LINE_WORDS);
  localparam int IB  = $clog2(NUM_SETS);
  localparam int TGB = ADDR_WIDTH - OB - WB - IB;
  localparam int YB  = NUM_WAYS > 1 ? $clog2(NUM_WAYS) : 1;
  typedef enum logic [2:0] {IDLE, LOOKUP, FILL_REQ, FILL_WAIT, WR_REQ, WR_WAIT, RESP} state_t;
  state_t state;
  logic [DATA_WIDTH-1:0] data [NUM_WAYS][NUM_SETS][LINE_WORDS];
  logic [TGB-1:0] tags [NUM_WAYS][NUM_SETS];
  logic [NUM_SETS-1:0] valid [NUM_WAYS];
  logic [YB-1:0] rr [NUM_SETS];
  logic [ADDR_WIDTH-1:OB] addr_q;
  logic we_q, flush_pend, use_rr, hit, inv_found, fill_ret, rd_hit, unused_off;
  logic [BW-1:0] be_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [YB-1:0] vict, hit_way, inv_way, new_vict;
  logic [WB:0] iss_cnt, ret_cnt;
  logic [IB-1:0] idx;
  logic [WB-1:0] word;
  logic [TGB-1:0] tag;
  assign unused_off = ^addr_i[OB-1:0];
  assign idx = addr_q[OB+WB +: IB];
  assign word = addr_q[OB +: WB];
  assign tag = addr_q[ADDR_WIDTH-1 -: TGB];
  // lowest matching / lowest invalid way wins because the scan runs downwards
  always_comb begin
    hit = 1'b0;
    hit_way = '0;
    inv_found = 1'b0;
    inv_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (valid[w][idx] && tags[w][idx] == tag) begin
        hit = 1'b1;
        hit_way = YB'(w);
      end
      if (!valid[w][idx]) begin
        inv_found = 1'b1;
        inv_way = YB'(w);
      end
    end
  end
  assign new_vict = inv_found ? inv_way : rr[idx];
  assign fill_ret = (state == FILL_REQ || state == FILL_WAIT) && mem_rvalid_i;
  assign rd_hit = state == LOOKUP && !we_q && hit;
  assign gnt_o = state == IDLE && req_i && !flush_i && !flush_pend && !rst;
  assign rvalid_o = rd_hit || state == RESP || (state == WR_WAIT && mem_rvalid_i);
  assign rdata_o = state == RESP ? data[vict][idx][word] : rd_hit ? data[hit_way][idx][word] : '0;
  always_ff @(posedge clk) begin
    if (state == LOOKUP && we_q && hit)
      for (int b = 0; b < BW; b++)
        if (be_q[b]) data[hit_way][idx][word][8*b +: 8] <= wdata_q[8*b +: 8];
    if (fill_ret) data[vict][idx][ret_cnt[WB-1:0]] <= mem_rdata_i;
    if (state == LOOKUP && !we_q && !hit) tags[new_vict][idx] <= tag;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      for (int w = 0; w < NUM_WAYS; w++) valid[w] <= '0;
      for (int s = 0; s < NUM_SETS; s++) rr[s] <= '0;
      hit_count_o <= '0;
      miss_count_o <= '0;
      mem_req_o <= 1'b0;
      mem_we_o <= 1'b0;
      mem_addr_o <= '0;
      mem_be_o <= '0;
      mem_wdata_o <= '0;
      addr_q <= '0;
      we_q <= 1'b0;
      be_q <= '0;
      wdata_q <= '0;
      flush_pend <= 1'b0;
      use_rr <= 1'b0;
      vict <= '0;
      iss_cnt <= '0;
      ret_cnt <= '0;
    end else begin
      if (flush_i && state != IDLE) flush_pend <= 1'b1;
      case (state)
        IDLE:
          if (flush_i || flush_pend) begin
            for (int w = 0; w < NUM_WAYS; w++) valid[w] <= '0;
            flush_pend <= 1'b0;
          end else if (req_i) begin
            addr_q <= addr_i[ADDR_WIDTH-1:OB];
            we_q <= we_i;
            be_q <= be_i;
            wdata_q <= wdata_i;
            state <= LOOKUP;
          end
        LOOKUP: begin
          if (hit) hit_count_o <= hit_count_o + 32'd1;
          else miss_count_o <= miss_count_o + 32'd1;
          if (we_q) begin
            mem_req_o <= 1'b1;
            mem_we_o <= 1'b1;
            mem_addr_o <= {addr_q, {OB{1'b0}}};
            mem_be_o <= be_q;
            mem_wdata_o <= wdata_q;
            state <= WR_REQ;
          end else if (hit) state <= IDLE;
          else begin
            // victim is invalidated up front so an aborted fill never leaves a stale line valid
            vict <= new_vict;
            use_rr <= !inv_found;
            valid[new_vict][idx] <= 1'b0;
            mem_req_o <= 1'b1;
            mem_we_o <= 1'b0;
            mem_be_o <= '1;
            mem_addr_o <= {addr_q[ADDR_WIDTH-1:OB+WB], {(OB+WB){1'b0}}};
            iss_cnt <= '0;
            ret_cnt <= '0;
            state <= FILL_REQ;
          end
        end
        FILL_REQ, FILL_WAIT: begin
          if (state == FILL_REQ && mem_req_o && mem_gnt_i) begin
            iss_cnt <= iss_cnt + 1'b1;
            mem_addr_o <= mem_addr_o + ADDR_WIDTH'(BW);
            if (iss_cnt == (WB+1)'(LINE_WORDS - 1)) begin
              mem_req_o <= 1'b0;
              state <= FILL_WAIT;
            end
          end
          if (mem_rvalid_i) begin
            ret_cnt <= ret_cnt + 1'b1;
            if (ret_cnt == (WB+1)'(LINE_WORDS - 1)) begin
              valid[vict][idx] <= 1'b1;
              if (use_rr) rr[idx] <= YB'((int'(vict) + 1) % NUM_WAYS);
              state <= RESP;
            end
          end
        end
        RESP: state <= IDLE;
        WR_REQ:
          if (mem_gnt_i) begin
            mem_req_o <= 1'b0;
            mem_we_o <= 1'b0;
            state <= WR_WAIT;
          end
        WR_WAIT: if (mem_rvalid_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sa_cache_ctrl.sv
// tb_sa_cache_ctrl: scoreboard bench with randomized memory stalls and a behavioural cache/memory reference
module tb_sa_cache_ctrl;
  localparam int NW = 2;
  localparam int NS = 64;
  logic clk = 0, rst = 1, flush_i = 0, req_i = 0, we_i = 0, mem_gnt_i = 0, mem_rvalid_i = 0;
  logic gnt_o, rvalid_o, mem_req_o, mem_we_o;
  logic [31:0] addr_i = 0, wdata_i = 0, rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i = 0;
  logic [31:0] hit_count_o, miss_count_o;
  logic [3:0] be_i = 0, mem_be_o;

  sa_cache_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_WAYS(NW), .NUM_SETS(NS), .LINE_WORDS(4)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i),
    .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .hit_count_o(hit_count_o), .miss_count_o(miss_count_o));

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;
  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] dflt(logic [31:0] a);
    return 32'h40000 + ((a - 32'h100000) >> 2);
  endfunction

  // memory slave with random grant and response stalls
  typedef struct {logic [31:0] data; int due;} rsp_t;
  typedef struct {logic we; logic [31:0] addr; logic [31:0] data; logic [3:0] be;} mtx_t;
  logic [31:0] smem [int unsigned];
  rsp_t rq[$];
  mtx_t mlog[$];
  int max_stall = 5;
  initial begin
    int stall = 0;
    logic [31:0] w;
    forever begin
      @(negedge clk);
      mem_gnt_i = 0;
      mem_rvalid_i = 0;
      mem_rdata_i = 0;
      if (rq.size() > 0 && rq[0].due <= cyc) begin
        mem_rvalid_i = 1;
        mem_rdata_i = rq[0].data;
        void'(rq.pop_front());
      end
      if (mem_req_o) begin
        if (stall > 0) stall--;
        else begin
          mem_gnt_i = 1;
          stall = $urandom_range(max_stall);
          mlog.push_back('{mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o});
          w = smem.exists(mem_addr_o >> 2) ? smem[mem_addr_o >> 2] : dflt(mem_addr_o);
          if (mem_we_o) begin
            for (int b = 0; b < 4; b++) if (mem_be_o[b]) w[8*b +: 8] = mem_wdata_o[8*b +: 8];
            smem[mem_addr_o >> 2] = w;
            w = 0;
          end
          rq.push_back('{w, cyc + 1 + int'($urandom_range(max_stall))});
        end
      end
    end
  end

  // reference: memory image plus spec-level replacement model
  logic [31:0] rmem [int unsigned];
  bit mvalid [NS][NW];
  logic [31:0] mtag [NS][NW];
  int mrr [NS];
  int m_hits = 0, m_miss = 0, n_lookups = 0;

  function automatic logic [31:0] ref_rd(logic [31:0] a);
    return rmem.exists(a >> 2) ? rmem[a >> 2] : dflt(a);
  endfunction

  function automatic void ref_wr(logic [31:0] a, logic [3:0] be, logic [31:0] d);
    logic [31:0] w = ref_rd(a);
    for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
    rmem[a >> 2] = w;
  endfunction

  function automatic bit model(logic [31:0] a, logic we);
    int s = int'((a >> 4) % NS);
    logic [31:0] t = a >> 10;
    int v = -1;
    for (int w = 0; w < NW; w++) if (mvalid[s][w] && mtag[s][w] == t) return 1;
    if (!we) begin
      for (int w = NW - 1; w >= 0; w--) if (!mvalid[s][w]) v = w;
      if (v < 0) begin
        v = mrr[s];
        mrr[s] = (v + 1) % NW;
      end
      mvalid[s][v] = 1;
      mtag[s][v] = t;
    end
    return 0;
  endfunction

  typedef struct {logic we; logic [31:0] data; bit hit; int gcyc;} exp_t;
  exp_t sb[$];

  task automatic do_req(logic [31:0] a, logic we, logic [3:0] be, logic [31:0] wd);
    int n = 0;
    exp_t e;
    @(negedge clk);
    req_i = 1; addr_i = a; we_i = we; be_i = be; wdata_i = wd;
    #1;
    while (!gnt_o && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!gnt_o) begin
      check("gnt_timeout", 32'(gnt_o), 32'd1);
      req_i = 0;
      return;
    end
    e.hit = model(a, we);
    e.we = we;
    e.gcyc = cyc;
    e.data = we ? 32'd0 : ref_rd(a);
    if (we) ref_wr(a, be, wd);
    sb.push_back(e);
    n_lookups++;
    if (e.hit) m_hits++; else m_miss++;
    @(posedge clk);
    #1;
    req_i = 0;
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush_i = 1;
    for (int s = 0; s < NS; s++) for (int w = 0; w < NW; w++) mvalid[s][w] = 0;
    @(negedge clk);
    flush_i = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(sb.size()), 32'd0);
    @(negedge clk);
  endtask

  // monitor: pops the scoreboard whenever the DUT responds
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rvalid_o) begin
        if (sb.size() == 0) check("unexpected_rvalid", 32'(rvalid_o), 32'd0);
        else begin
          e = sb.pop_front();
          if (!e.we) check("rdata", rdata_o, e.data);
          if (!e.we && e.hit) check("hit_latency", 32'(cyc - e.gcyc), 32'd1);
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ml0;
    logic [31:0] a;
    repeat (3) @(negedge clk);
    check("rst_gnt", 32'(gnt_o), 32'd0);
    check("rst_rvalid", 32'(rvalid_o), 32'd0);
    check("rst_mem_req", 32'(mem_req_o), 32'd0);
    check("rst_mem_we", 32'(mem_we_o), 32'd0);
    check("rst_mem_addr", mem_addr_o, 32'd0);
    check("rst_hits", hit_count_o, 32'd0);
    check("rst_miss", miss_count_o, 32'd0);
    rst = 0;

    ml0 = mlog.size();
    do_req(32'h100000, 0, 4'h0, 0);
    drain();
    check("t1_nreads", 32'(mlog.size() - ml0), 32'd4);
    for (int i = 0; i < 4 && ml0 + i < mlog.size(); i++) begin
      check("t1_addr", mlog[ml0 + i].addr, 32'h100000 + 32'(4 * i));
      check("t1_we", 32'(mlog[ml0 + i].we), 32'd0);
    end
    check("t1_miss", miss_count_o, 32'd1);
    check("t1_hit", hit_count_o, 32'd0);

    ml0 = mlog.size();
    do_req(32'h100004, 0, 4'h0, 0);
    drain();
    check("t2_no_mem", 32'(mlog.size() - ml0), 32'd0);
    check("t2_hit", hit_count_o, 32'd1);

    do_req(32'h100400, 0, 4'h0, 0);
    do_req(32'h100800, 0, 4'h0, 0);
    do_req(32'h100000, 0, 4'h0, 0);
    do_req(32'h100800, 0, 4'h0, 0);
    drain();
    check("t3_miss", miss_count_o, 32'd4);
    check("t3_hit", hit_count_o, 32'd2);

    do_req(32'h100800, 1, 4'hF, 32'h11223344);
    do_req(32'h100800, 1, 4'h3, 32'hDEADBEEF);
    drain();
    if (mlog.size() > 0) begin
      check("t4_wr_we", 32'(mlog[$].we), 32'd1);
      check("t4_wr_addr", mlog[$].addr, 32'h100800);
      check("t4_wr_data", mlog[$].data, 32'hDEADBEEF);
      check("t4_wr_be", 32'(mlog[$].be), 32'h3);
    end
    do_req(32'h100800, 0, 4'h0, 0);
    drain();
    check("t4_hit", hit_count_o, 32'd5);
    ml0 = mlog.size();
    do_req(32'h200000, 1, 4'h3, 32'hDEADBEEF);
    drain();
    check("t4_uncached_nmem", 32'(mlog.size() - ml0), 32'd1);
    check("t4_miss", miss_count_o, 32'd5);

    do_req(32'h300000, 0, 4'h0, 0);
    @(negedge clk);
    do_flush();
    drain();
    do_req(32'h300000, 0, 4'h0, 0);
    drain();
    check("t5_miss", miss_count_o, 32'd7);

    for (int i = 0; i < 2000; i++) begin
      a = 32'h100000 + 32'($urandom_range(3)) * 32'h400 + 32'($urandom_range(3)) * 32'h10
          + 32'($urandom_range(3)) * 4;
      if ($urandom_range(9) == 0) a = a + 32'h400000;
      if ($urandom_range(63) == 0) do_flush();
      if ($urandom_range(9) < 3) do_req(a, 1, 4'($urandom_range(1, 15)), $urandom);
      else do_req(a, 0, 4'h0, 0);
    end
    drain();
    check("t6_lookups", hit_count_o + miss_count_o, 32'(n_lookups));
    check("t6_hits", hit_count_o, 32'(m_hits));
    check("t6_miss", miss_count_o, 32'(m_miss));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
